// File: rtl/id_ex_operand_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module  : id_ex_operand_stage_pkg
// Brief   : Shared widths, operand-select encodings and ALU function codes.
// Revision: 1.0 - initial release
// ============================================================================
package id_ex_operand_stage_pkg;

  localparam int XLEN = 32;
  localparam int RA_W = 5;

  typedef enum logic {
    OP1_RS1 = 1'b0,
    OP1_PC  = 1'b1
  } op1_sel_e;

  typedef enum logic {
    OP2_RS2 = 1'b0,
    OP2_IMM = 1'b1
  } op2_sel_e;

  typedef enum logic [2:0] {
    F3_ADD  = 3'b000,
    F3_SLL  = 3'b001,
    F3_SLT  = 3'b010,
    F3_SLTU = 3'b011,
    F3_XOR  = 3'b100,
    F3_SR   = 3'b101,
    F3_OR   = 3'b110,
    F3_AND  = 3'b111
  } func3_e;

  localparam logic [6:0] FUNC7_ALT = 7'h20;

endpackage
`default_nettype wire

// File: rtl/id_ex_operand_stage_if.sv
`default_nettype none
// ============================================================================
// Module  : id_ex_operand_stage_if
// Brief   : Decode-side, EX-side and forwarding signals of the ID/EX stage.
// Revision: 1.0 - initial release
// ============================================================================
interface id_ex_operand_stage_if #(
  parameter int XLEN = 32,
  parameter int RA_W = 5
);

  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] in_pc;
  logic [RA_W-1:0] in_rs1_addr;
  logic [RA_W-1:0] in_rs2_addr;
  logic [XLEN-1:0] in_rs1_data;
  logic [XLEN-1:0] in_rs2_data;
  logic [XLEN-1:0] in_imm;
  logic [2:0]      in_func3;
  logic [6:0]      in_func7;
  logic [RA_W-1:0] in_rd_addr;
  logic            in_op1_sel;
  logic            in_op2_sel;
  logic            in_is_load;
  logic            flush;

  logic            exmem_wr;
  logic [RA_W-1:0] exmem_rd;
  logic [XLEN-1:0] exmem_data;
  logic            memwb_wr;
  logic [RA_W-1:0] memwb_rd;
  logic [XLEN-1:0] memwb_data;

  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_op1;
  logic [XLEN-1:0] out_op2;
  logic [2:0]      out_func3;
  logic [6:0]      out_func7;
  logic [RA_W-1:0] out_rd_addr;
  logic [XLEN-1:0] out_store_data;
  logic            out_is_load;
  logic            hazard_stall;

  modport master (
    output in_valid, in_pc, in_rs1_addr, in_rs2_addr, in_rs1_data, in_rs2_data,
           in_imm, in_func3, in_func7, in_rd_addr, in_op1_sel, in_op2_sel,
           in_is_load, flush,
           exmem_wr, exmem_rd, exmem_data, memwb_wr, memwb_rd, memwb_data,
           out_ready,
    input  in_ready, out_valid, out_op1, out_op2, out_func3, out_func7,
           out_rd_addr, out_store_data, out_is_load, hazard_stall
  );

  modport slave (
    input  in_valid, in_pc, in_rs1_addr, in_rs2_addr, in_rs1_data, in_rs2_data,
           in_imm, in_func3, in_func7, in_rd_addr, in_op1_sel, in_op2_sel,
           in_is_load, flush,
           exmem_wr, exmem_rd, exmem_data, memwb_wr, memwb_rd, memwb_data,
           out_ready,
    output in_ready, out_valid, out_op1, out_op2, out_func3, out_func7,
           out_rd_addr, out_store_data, out_is_load, hazard_stall
  );

endinterface
`default_nettype wire

// File: rtl/id_ex_operand_stage_fwd_mux.sv
`default_nettype none
// ============================================================================
// Module  : id_ex_operand_stage_fwd_mux
// Brief   : Single-operand bypass selector; EX/MEM beats MEM/WB, x0 never bypassed.
// Revision: 1.0 - initial release
// ============================================================================
module id_ex_operand_stage_fwd_mux #(
  parameter int XLEN = 32,
  parameter int RA_W = 5
) (
  input  wire logic [RA_W-1:0] i_addr,
  input  wire logic [XLEN-1:0] i_raw,
  input  wire logic            i_exmem_wr,
  input  wire logic [RA_W-1:0] i_exmem_rd,
  input  wire logic [XLEN-1:0] i_exmem_data,
  input  wire logic            i_memwb_wr,
  input  wire logic [RA_W-1:0] i_memwb_rd,
  input  wire logic [XLEN-1:0] i_memwb_data,
  output logic      [XLEN-1:0] o_data
);

  logic w_nonzero;
  logic w_hit_exmem;
  logic w_hit_memwb;

  assign w_nonzero   = (i_addr != '0);
  assign w_hit_exmem = w_nonzero && i_exmem_wr && (i_exmem_rd == i_addr);
  assign w_hit_memwb = w_nonzero && i_memwb_wr && (i_memwb_rd == i_addr);

  always_comb begin
    o_data = i_raw;
    if (w_hit_exmem) begin
      o_data = i_exmem_data;
    end else if (w_hit_memwb) begin
      o_data = i_memwb_data;
    end
  end

endmodule
`default_nettype wire

// File: rtl/id_ex_operand_stage.sv
`default_nettype none
// ============================================================================
// Module  : id_ex_operand_stage
// Brief   : ID/EX register with output-side forwarding, load-use bubbles, flush.
// Revision: 1.0 - initial release
// ============================================================================
module id_ex_operand_stage #(
  parameter int XLEN = 32,
  parameter int RA_W = 5
) (
  input  wire logic             clk,
  input  wire logic             rst,
  id_ex_operand_stage_if.slave  bus
);

  import id_ex_operand_stage_pkg::*;

  logic            r_valid;
  logic [XLEN-1:0] r_pc;
  logic [RA_W-1:0] r_rs1_addr;
  logic [RA_W-1:0] r_rs2_addr;
  logic [XLEN-1:0] r_rs1_data;
  logic [XLEN-1:0] r_rs2_data;
  logic [XLEN-1:0] r_imm;
  logic [2:0]      r_func3;
  logic [6:0]      r_func7;
  logic [RA_W-1:0] r_rd_addr;
  logic            r_op1_sel;
  logic            r_op2_sel;
  logic            r_is_load;

  logic            w_rs1_dep;
  logic            w_rs2_dep;
  logic            w_load_use;
  logic            w_in_ready;
  logic            w_in_fire;
  logic            w_out_fire;
  logic [XLEN-1:0] w_rs1_fwd;
  logic [XLEN-1:0] w_rs2_fwd;

  // rs2 counts even for immediate forms because it may also feed store data.
  assign w_rs1_dep  = (bus.in_op1_sel == OP1_RS1) && (bus.in_rs1_addr == r_rd_addr);
  assign w_rs2_dep  = (bus.in_rs2_addr == r_rd_addr);
  assign w_load_use = r_valid && r_is_load && (r_rd_addr != '0) && bus.in_valid
                      && (w_rs1_dep || w_rs2_dep);

  assign w_in_ready = bus.flush || ((!r_valid || bus.out_ready) && !w_load_use);
  assign w_in_fire  = bus.in_valid && w_in_ready;
  assign w_out_fire = r_valid && bus.out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid    <= 1'b0;
      r_pc       <= '0;
      r_rs1_addr <= '0;
      r_rs2_addr <= '0;
      r_rs1_data <= '0;
      r_rs2_data <= '0;
      r_imm      <= '0;
      r_func3    <= '0;
      r_func7    <= '0;
      r_rd_addr  <= '0;
      r_op1_sel  <= 1'b0;
      r_op2_sel  <= 1'b0;
      r_is_load  <= 1'b0;
    end else if (bus.flush) begin
      r_valid <= 1'b0;
    end else if (w_in_fire) begin
      r_valid    <= 1'b1;
      r_pc       <= bus.in_pc;
      r_rs1_addr <= bus.in_rs1_addr;
      r_rs2_addr <= bus.in_rs2_addr;
      r_rs1_data <= bus.in_rs1_data;
      r_rs2_data <= bus.in_rs2_data;
      r_imm      <= bus.in_imm;
      r_func3    <= bus.in_func3;
      r_func7    <= bus.in_func7;
      r_rd_addr  <= bus.in_rd_addr;
      r_op1_sel  <= bus.in_op1_sel;
      r_op2_sel  <= bus.in_op2_sel;
      r_is_load  <= bus.in_is_load;
    end else if (w_out_fire) begin
      r_valid <= 1'b0;
    end
  end

  // Bypass after the register so a stalled operand keeps picking up new results.
  id_ex_operand_stage_fwd_mux #(
    .XLEN (XLEN),
    .RA_W (RA_W)
  ) u_fwd_rs1 (
    .i_addr       (r_rs1_addr),
    .i_raw        (r_rs1_data),
    .i_exmem_wr   (bus.exmem_wr),
    .i_exmem_rd   (bus.exmem_rd),
    .i_exmem_data (bus.exmem_data),
    .i_memwb_wr   (bus.memwb_wr),
    .i_memwb_rd   (bus.memwb_rd),
    .i_memwb_data (bus.memwb_data),
    .o_data       (w_rs1_fwd)
  );

  id_ex_operand_stage_fwd_mux #(
    .XLEN (XLEN),
    .RA_W (RA_W)
  ) u_fwd_rs2 (
    .i_addr       (r_rs2_addr),
    .i_raw        (r_rs2_data),
    .i_exmem_wr   (bus.exmem_wr),
    .i_exmem_rd   (bus.exmem_rd),
    .i_exmem_data (bus.exmem_data),
    .i_memwb_wr   (bus.memwb_wr),
    .i_memwb_rd   (bus.memwb_rd),
    .i_memwb_data (bus.memwb_data),
    .o_data       (w_rs2_fwd)
  );

  assign bus.in_ready       = w_in_ready;
  assign bus.hazard_stall   = w_load_use && !bus.flush;
  assign bus.out_valid      = r_valid;
  assign bus.out_op1        = (r_op1_sel == OP1_PC)  ? r_pc  : w_rs1_fwd;
  assign bus.out_op2        = (r_op2_sel == OP2_IMM) ? r_imm : w_rs2_fwd;
  assign bus.out_store_data = w_rs2_fwd;
  assign bus.out_func3      = r_func3;
  assign bus.out_func7      = r_func7;
  assign bus.out_rd_addr    = r_rd_addr;
  assign bus.out_is_load    = r_is_load;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_operand_stage.sv
`default_nettype none
// ============================================================================
// Module  : tb_id_ex_operand_stage
// Brief   : Directed and randomized checks of the ID/EX operand stage.
// Revision: 1.0 - initial release
// ============================================================================
module tb_id_ex_operand_stage;

  localparam int XLEN = 32;
  localparam int RA_W = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  id_ex_operand_stage_if #(.XLEN(XLEN), .RA_W(RA_W)) bus ();

  id_ex_operand_stage #(.XLEN(XLEN), .RA_W(RA_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rs1a;
    logic [4:0]  rs2a;
    logic [31:0] rs1d;
    logic [31:0] rs2d;
    logic [31:0] imm;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rd;
    logic        s1;
    logic        s2;
    logic        ld;
  } instr_t;

  // Reference: the single instruction the stage should be holding.
  bit     m_valid;
  instr_t m_held;

  function automatic logic [31:0] m_fwd(logic [4:0] a, logic [31:0] raw);
    if (a == 5'd0) return raw;
    if (bus.exmem_wr && bus.exmem_rd == a) return bus.exmem_data;
    if (bus.memwb_wr && bus.memwb_rd == a) return bus.memwb_data;
    return raw;
  endfunction

  function automatic bit m_load_use();
    bit reads_rd;
    reads_rd = (!bus.in_op1_sel && bus.in_rs1_addr == m_held.rd) || (bus.in_rs2_addr == m_held.rd);
    return m_valid && m_held.ld && m_held.rd != 5'd0 && bus.in_valid && reads_rd;
  endfunction

  function automatic bit m_in_ready();
    if (bus.flush) return 1'b1;
    if (m_load_use()) return 1'b0;
    return !m_valid || bus.out_ready;
  endfunction

  function automatic logic [31:0] m_op1();
    return m_held.s1 ? m_held.pc : m_fwd(m_held.rs1a, m_held.rs1d);
  endfunction

  function automatic logic [31:0] m_op2();
    return m_held.s2 ? m_held.imm : m_fwd(m_held.rs2a, m_held.rs2d);
  endfunction

  function automatic instr_t incoming();
    instr_t t;
    t.pc = bus.in_pc; t.rs1a = bus.in_rs1_addr; t.rs2a = bus.in_rs2_addr;
    t.rs1d = bus.in_rs1_data; t.rs2d = bus.in_rs2_data; t.imm = bus.in_imm;
    t.f3 = bus.in_func3; t.f7 = bus.in_func7; t.rd = bus.in_rd_addr;
    t.s1 = bus.in_op1_sel; t.s2 = bus.in_op2_sel; t.ld = bus.in_is_load;
    return t;
  endfunction

  task automatic drive(input instr_t t, input bit v);
    bus.in_valid = v; bus.in_pc = t.pc;
    bus.in_rs1_addr = t.rs1a; bus.in_rs2_addr = t.rs2a;
    bus.in_rs1_data = t.rs1d; bus.in_rs2_data = t.rs2d; bus.in_imm = t.imm;
    bus.in_func3 = t.f3; bus.in_func7 = t.f7; bus.in_rd_addr = t.rd;
    bus.in_op1_sel = t.s1; bus.in_op2_sel = t.s2; bus.in_is_load = t.ld;
  endtask

  task automatic no_fwd();
    bus.exmem_wr = 0; bus.exmem_rd = 0; bus.exmem_data = 0;
    bus.memwb_wr = 0; bus.memwb_rd = 0; bus.memwb_data = 0;
  endtask

  // Advance one clock and move the reference model along with it.
  task automatic tick();
    bit     acc, fl, ordy;
    instr_t nxt;
    acc  = bus.in_valid && m_in_ready();
    fl   = bus.flush;
    ordy = bus.out_ready;
    nxt  = incoming();
    @(posedge clk);
    if (fl) m_valid = 0;
    else if (acc) begin m_valid = 1; m_held = nxt; end
    else if (m_valid && ordy) m_valid = 0;
    #1;
  endtask

  function automatic instr_t mk(logic [31:0] pc, logic [4:0] rs1a, logic [31:0] rs1d,
                                logic [4:0] rs2a, logic [31:0] rs2d, logic [31:0] imm,
                                logic [4:0] rd, logic s1, logic s2, logic ld);
    instr_t t;
    t.pc = pc; t.rs1a = rs1a; t.rs1d = rs1d; t.rs2a = rs2a; t.rs2d = rs2d;
    t.imm = imm; t.rd = rd; t.s1 = s1; t.s2 = s2; t.ld = ld;
    t.f3 = 3'b000; t.f7 = 7'h00;
    return t;
  endfunction

  task automatic test_reset();
    #1;
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.out_op1 !== 32'd0 || bus.out_op2 !== 32'd0) begin
      n_errors++;
      $display("FAIL reset_initial: valid=%b op1=%h op2=%h required 0/0/0",
               bus.out_valid, bus.out_op1, bus.out_op2);
    end
    @(negedge clk);
    rst = 0;
    bus.out_ready = 0;
    drive(mk(32'h40, 5'd7, 32'h1234, 5'd8, 32'h5678, 32'h9, 5'd6, 0, 0, 1), 1);
    tick();
    drive('0, 0);
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.out_rd_addr !== 5'd6) begin
      n_errors++;
      $display("FAIL reset_pre_valid: valid=%b rd=%0d required 1/6", bus.out_valid, bus.out_rd_addr);
    end
    #2 rst = 1;
    #1;
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.out_op1 !== 32'd0 || bus.out_op2 !== 32'd0 ||
        bus.out_store_data !== 32'd0 || bus.out_func3 !== 3'd0 || bus.out_func7 !== 7'd0 ||
        bus.out_rd_addr !== 5'd0 || bus.out_is_load !== 1'b0 || bus.hazard_stall !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_async: valid=%b op1=%h op2=%h sd=%h f3=%h f7=%h rd=%h ld=%b hz=%b required all 0",
               bus.out_valid, bus.out_op1, bus.out_op2, bus.out_store_data, bus.out_func3,
               bus.out_func7, bus.out_rd_addr, bus.out_is_load, bus.hazard_stall);
    end
    m_valid = 0;
    m_held  = '0;
    #1 rst = 0;
  endtask

  task automatic test_addi();
    instr_t t;
    t = mk(32'h100, 5'd1, 32'd5, 5'd9, 32'd77, 32'd7, 5'd2, 0, 1, 0);
    bus.out_ready = 1;
    drive(t, 1);
    #1;
    n_checks++;
    if (bus.in_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL addi_in_ready: got %b required 1", bus.in_ready);
    end
    tick();
    drive('0, 0);
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.out_op1 !== 32'd5 || bus.out_op2 !== 32'd7 ||
        bus.out_func3 !== 3'b000 || bus.out_store_data !== 32'd77) begin
      n_errors++;
      $display("FAIL addi_out: valid=%b op1=%h op2=%h f3=%b sd=%h required 1/5/7/000/4d",
               bus.out_valid, bus.out_op1, bus.out_op2, bus.out_func3, bus.out_store_data);
    end
    tick();
    n_checks++;
    if (bus.out_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL addi_drain: valid=%b required 0", bus.out_valid);
    end
  endtask

  task automatic test_fwd_priority();
    bus.out_ready = 0;
    drive(mk(32'h200, 5'd3, 32'd1, 5'd4, 32'd2, 32'd0, 5'd10, 0, 0, 0), 1);
    tick();
    drive('0, 0);
    bus.exmem_wr = 1; bus.exmem_rd = 5'd3; bus.exmem_data = 32'hAA;
    bus.memwb_wr = 1; bus.memwb_rd = 5'd3; bus.memwb_data = 32'hBB;
    #1;
    n_checks++;
    if (bus.out_op1 !== 32'hAA) begin
      n_errors++;
      $display("FAIL fwd_exmem_first: op1=%h required aa", bus.out_op1);
    end
    bus.exmem_wr = 0;
    #1;
    n_checks++;
    if (bus.out_op1 !== 32'hBB) begin
      n_errors++;
      $display("FAIL fwd_memwb: op1=%h required bb", bus.out_op1);
    end
    bus.memwb_wr = 0;
    #1;
    n_checks++;
    if (bus.out_op1 !== 32'd1) begin
      n_errors++;
      $display("FAIL fwd_none: op1=%h required 1", bus.out_op1);
    end
    bus.out_ready = 1;
    drive(mk(32'h204, 5'd0, 32'h11, 5'd0, 32'h22, 32'd0, 5'd12, 0, 0, 0), 1);
    tick();
    drive('0, 0);
    bus.out_ready = 0;
    bus.exmem_wr = 1; bus.exmem_rd = 5'd0; bus.exmem_data = 32'hCC;
    bus.memwb_wr = 1; bus.memwb_rd = 5'd0; bus.memwb_data = 32'hCC;
    #1;
    n_checks++;
    if (bus.out_op1 !== 32'h11 || bus.out_store_data !== 32'h22) begin
      n_errors++;
      $display("FAIL fwd_x0: op1=%h sd=%h required 11/22", bus.out_op1, bus.out_store_data);
    end
    no_fwd();
    bus.out_ready = 1;
    tick();
  endtask

  task automatic test_load_use();
    bus.out_ready = 1;
    drive(mk(32'h300, 5'd1, 32'd0, 5'd2, 32'd0, 32'd8, 5'd5, 0, 1, 1), 1);
    tick();
    drive(mk(32'h304, 5'd5, 32'h55, 5'd6, 32'h66, 32'd0, 5'd7, 0, 0, 0), 1);
    #1;
    n_checks++;
    if (bus.hazard_stall !== 1'b1 || bus.in_ready !== 1'b0) begin
      n_errors++;
      $display("FAIL load_use_detect: hz=%b rdy=%b required 1/0", bus.hazard_stall, bus.in_ready);
    end
    tick();
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.hazard_stall !== 1'b0 || bus.in_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL load_use_bubble: valid=%b hz=%b rdy=%b required 0/0/1",
               bus.out_valid, bus.hazard_stall, bus.in_ready);
    end
    tick();
    drive('0, 0);
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.out_rd_addr !== 5'd7 || bus.out_op1 !== 32'h55) begin
      n_errors++;
      $display("FAIL load_use_capture: valid=%b rd=%0d op1=%h required 1/7/55",
               bus.out_valid, bus.out_rd_addr, bus.out_op1);
    end
    // Store-style consumer: rs2 matches although op2 selects the immediate.
    drive(mk(32'h308, 5'd1, 32'd0, 5'd2, 32'd0, 32'd4, 5'd9, 0, 1, 1), 1);
    tick();
    drive(mk(32'h30C, 5'd3, 32'd0, 5'd9, 32'd0, 32'd4, 5'd0, 0, 1, 0), 1);
    #1;
    n_checks++;
    if (bus.hazard_stall !== 1'b1) begin
      n_errors++;
      $display("FAIL load_use_store: hz=%b required 1", bus.hazard_stall);
    end
    drive('0, 0);
    tick();
  endtask

  task automatic test_backpressure();
    logic [31:0] v;
    bus.out_ready = 1;
    drive(mk(32'h400, 5'd4, 32'd9, 5'd0, 32'd0, 32'd3, 5'd11, 0, 1, 0), 1);
    tick();
    bus.out_ready = 0;
    drive(mk(32'h404, 5'd1, 32'd0, 5'd2, 32'd0, 32'd0, 5'd13, 1, 1, 0), 1);
    for (int i = 0; i < 3; i++) begin
      v = $urandom;
      bus.exmem_wr = 1; bus.exmem_rd = 5'd4; bus.exmem_data = v;
      #1;
      n_checks++;
      if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.out_rd_addr !== 5'd11 ||
          bus.out_op2 !== 32'd3 || bus.out_op1 !== v) begin
        n_errors++;
        $display("FAIL stall_hold[%0d]: rdy=%b valid=%b rd=%0d op2=%h op1=%h required 0/1/11/3/%h",
                 i, bus.in_ready, bus.out_valid, bus.out_rd_addr, bus.out_op2, bus.out_op1, v);
      end
      tick();
    end
    no_fwd();
    bus.out_ready = 1;
    tick();
    drive('0, 0);
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.out_rd_addr !== 5'd13 || bus.out_op1 !== 32'h404) begin
      n_errors++;
      $display("FAIL stall_release: valid=%b rd=%0d op1=%h required 1/13/404",
               bus.out_valid, bus.out_rd_addr, bus.out_op1);
    end
    tick();
  endtask

  task automatic test_flush();
    bus.out_ready = 0;
    drive(mk(32'h500, 5'd1, 32'd0, 5'd2, 32'd0, 32'd0, 5'd8, 0, 0, 1), 1);
    tick();
    drive(mk(32'h504, 5'd8, 32'd0, 5'd8, 32'd0, 32'd0, 5'd14, 0, 0, 0), 1);
    bus.flush = 1;
    #1;
    n_checks++;
    if (bus.in_ready !== 1'b1 || bus.hazard_stall !== 1'b0) begin
      n_errors++;
      $display("FAIL flush_ready: rdy=%b hz=%b required 1/0", bus.in_ready, bus.hazard_stall);
    end
    tick();
    bus.flush = 0;
    drive('0, 0);
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.out_rd_addr !== 5'd8) begin
      n_errors++;
      $display("FAIL flush_discard: valid=%b rd=%0d required 0/8", bus.out_valid, bus.out_rd_addr);
    end
  endtask

  task automatic test_random();
    instr_t t;
    for (int c = 0; c < 400; c++) begin
      t.pc = $urandom; t.rs1a = 5'($urandom_range(0, 7)); t.rs2a = 5'($urandom_range(0, 7));
      t.rs1d = $urandom; t.rs2d = $urandom; t.imm = $urandom;
      t.f3 = 3'($urandom); t.f7 = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
      t.rd = 5'($urandom_range(0, 7)); t.s1 = 1'($urandom); t.s2 = 1'($urandom);
      t.ld = ($urandom_range(0, 2) == 0);
      drive(t, $urandom_range(0, 3) != 0);
      bus.out_ready  = ($urandom_range(0, 3) != 0);
      bus.flush      = ($urandom_range(0, 15) == 0);
      bus.exmem_wr   = 1'($urandom); bus.exmem_rd = 5'($urandom_range(0, 7)); bus.exmem_data = $urandom;
      bus.memwb_wr   = 1'($urandom); bus.memwb_rd = 5'($urandom_range(0, 7)); bus.memwb_data = $urandom;
      #1;
      n_checks++;
      if (bus.out_valid !== m_valid || bus.in_ready !== m_in_ready() ||
          bus.hazard_stall !== (m_load_use() && !bus.flush)) begin
        n_errors++;
        $display("FAIL rand_ctrl[%0d]: valid=%b rdy=%b hz=%b required %b/%b/%b", c,
                 bus.out_valid, bus.in_ready, bus.hazard_stall,
                 m_valid, m_in_ready(), m_load_use() && !bus.flush);
      end
      n_checks++;
      if (bus.out_op1 !== m_op1() || bus.out_op2 !== m_op2() ||
          bus.out_store_data !== m_fwd(m_held.rs2a, m_held.rs2d)) begin
        n_errors++;
        $display("FAIL rand_operands[%0d]: op1=%h op2=%h sd=%h required %h/%h/%h", c,
                 bus.out_op1, bus.out_op2, bus.out_store_data,
                 m_op1(), m_op2(), m_fwd(m_held.rs2a, m_held.rs2d));
      end
      n_checks++;
      if (bus.out_func3 !== m_held.f3 || bus.out_func7 !== m_held.f7 ||
          bus.out_rd_addr !== m_held.rd || bus.out_is_load !== m_held.ld) begin
        n_errors++;
        $display("FAIL rand_fields[%0d]: f3=%h f7=%h rd=%h ld=%b required %h/%h/%h/%b", c,
                 bus.out_func3, bus.out_func7, bus.out_rd_addr, bus.out_is_load,
                 m_held.f3, m_held.f7, m_held.rd, m_held.ld);
      end
      tick();
    end
    bus.flush = 0;
  endtask

  initial begin
    m_valid = 0;
    m_held  = '0;
    drive('0, 0);
    no_fwd();
    bus.flush     = 0;
    bus.out_ready = 0;
    test_reset();
    test_addi();
    test_fwd_priority();
    test_load_use();
    test_backpressure();
    test_flush();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, required completion");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/id_ex_operand_stage.md
Name: id_ex_operand_stage

Overview:
- ID/EX pipeline register directly upstream of the ALU.
- Captures decoded instruction fields and raw register-file operands, then presents resolved op1/op2/func3/func7 to the ALU.
- Resolves EX/MEM and MEM/WB forwarding on the output side, so operands stay correct while the stage is stalled.
- Detects load-use hazards and inserts bubbles; supports flush from branch resolution.

Parameters:
- XLEN, 32, datapath width
- RA_W, 5, register address width

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- in_valid  in  1  decode has an instruction
- in_ready  out  1  stage accepts this cycle
- in_pc  in  XLEN  instruction PC
- in_rs1_addr, in_rs2_addr  in  RA_W  source register indices
- in_rs1_data, in_rs2_data  in  XLEN  register-file read data
- in_imm  in  XLEN  sign-extended immediate
- in_func3  in  3  ALU function select
- in_func7  in  7  ALU func7
- in_rd_addr  in  RA_W  destination index
- in_op1_sel  in  1  0=rs1, 1=pc
- in_op2_sel  in  1  0=rs2, 1=imm
- in_is_load  in  1  instruction is a load
- flush  in  1  discard held and incoming instruction
- exmem_wr, memwb_wr  in  1  forwarding source writes rd
- exmem_rd, memwb_rd  in  RA_W  forwarding destination
- exmem_data, memwb_data  in  XLEN  forwarding value
- out_valid  out  1  held instruction valid
- out_ready  in  1  EX accepts
- out_op1, out_op2  out  XLEN  resolved ALU operands
- out_func3  out  3  registered func3
- out_func7  out  7  registered func7
- out_rd_addr  out  RA_W  registered rd
- out_store_data  out  XLEN  forwarded rs2 value
- out_is_load  out  1  registered load flag
- hazard_stall  out  1  load-use bubble inserted this cycle

Behaviour:
- Reset (async, rst=1): out_valid=0; all registered fields 0. Outputs are therefore out_op1=out_op2=0, out_func3=0, out_func7=0, out_rd_addr=0, out_store_data=0, out_is_load=0, hazard_stall=0. Reset mid-transfer drops the held instruction.
- Fire conditions: out_fire = out_valid & out_ready; in_fire = in_valid & in_ready.
- load_use (combinational) = out_valid & out_is_load & out_rd_addr!=0 & in_valid & ((in_op1_sel==0 & in_rs1_addr==out_rd_addr) | (in_op2_sel==0 & in_rs2_addr==out_rd_addr) | (in_rs2_addr==out_rd_addr & out of store path)).
  - Simplification: rs2 match counts regardless of op2_sel, because rs2 is also used as store data.
- in_ready = flush | ((~out_valid | out_ready) & ~load_use).
- hazard_stall = load_use & ~flush.
- Register update, in priority order:
  1. flush → out_valid<=0.
  2. in_fire → capture all in_* fields; out_valid<=1.
  3. out_fire → out_valid<=0 (bubble; covers load_use).
  4. Otherwise hold.
- Stall: out_valid & ~out_ready holds every field unchanged; in_ready=0.
- Registered fields: pc, rs1/rs2 addr and data, imm, func3, func7, rd, sels, is_load.
- Forwarding is combinational from registered values and applies whether or not stalled:
  - fwd(addr, raw) = exmem_data if exmem_wr & exmem_rd==addr & addr!=0; else memwb_data if memwb_wr & memwb_rd==addr & addr!=0; else raw.
  - EX/MEM has priority over MEM/WB.
  - Register x0 is never forwarded.
- Operand outputs:
  - out_op1 = sel1 ? pc : fwd(rs1).
  - out_op2 = sel2 ? imm : fwd(rs2).
  - out_store_data = fwd(rs2) always.
- out_* fields are driven even when out_valid=0. Consumers must qualify with out_valid.
- Throughput: one instruction per cycle when out_ready=1 and no hazard. Latency is one cycle from in_fire to out_valid.

Decomposition:
- Shared package:
  - XLEN, RA_W
  - op-select encodings OP1_RS1/OP1_PC, OP2_RS2/OP2_IMM
  - func3 codes (ADD=000 … AND=111)
  - FUNC7_ALT=7'h20
- One natural sub-module, fwd_mux: a combinational single-operand forwarding selector, instantiated twice (rs1, rs2).

Test Plan:
- Reset: assert rst mid-stream with out_valid=1 → out_valid=0 and all outputs 0 immediately, before the next clk edge.
- Plain ADDI: pc=0x100, rs1 data=5, imm=7, sel2=1, func3=000 → next cycle out_valid=1, out_op1=5, out_op2=7; no forwarding.
- Forward priority: held rs1=x3 raw 1; exmem_wr rd=3 data=0xAA and memwb_wr rd=3 data=0xBB → out_op1=0xAA. Drop exmem_wr → 0xBB. rd=0 with data 0xCC is never forwarded.
- Load-use: held LW x5; upstream ADD uses rs1=x5 with out_ready=1 → hazard_stall=1, in_ready=0, next cycle out_valid=0; ADD captured the following cycle.
- Backpressure: out_ready=0 for 3 cycles → fields stable, in_ready=0. Change exmem_data during the stall → out_op1 tracks it.
- Flush with in_valid=1 and out_valid=1 → in_ready=1, next cycle out_valid=0, incoming instruction discarded.
